// File: rtl/conv_window_buffer.sv
// Streaming K x K sliding-window generator: buffers K-1 image lines and emits one
// flattened window per kernel position fully inside the image, in raster order.
module conv_window_buffer #(
    parameter int unsigned D_WIDTH    = 8,
    parameter int unsigned KERNEL     = 3,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [D_WIDTH-1:0]                in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [D_WIDTH*KERNEL*KERNEL-1:0]  out_window,
    output logic                              out_last
);

    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned WinW = D_WIDTH * KERNEL * KERNEL;

    localparam logic [ColW-1:0] ColFirst = ColW'(KERNEL - 1);
    localparam logic [ColW-1:0] ColLast  = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowFirst = RowW'(KERNEL - 1);
    localparam logic [RowW-1:0] RowLast  = RowW'(IMG_HEIGHT - 1);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            acc;
    logic            col_end;
    logic            row_end;
    logic            completing;

    logic [D_WIDTH-1:0] lb_q  [KERNEL-1][IMG_WIDTH];
    logic [D_WIDTH-1:0] win_q [KERNEL][KERNEL];
    logic [D_WIDTH-1:0] win_d [KERNEL][KERNEL];
    logic [WinW-1:0]    win_flat;

    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [WinW-1:0] out_window_q, out_window_d;

    assign in_ready   = !out_valid_q || out_ready;
    assign acc        = in_valid && in_ready;
    assign col_end    = (col_q == ColLast);
    assign row_end    = (row_q == RowLast);
    // Edge positions whose window would still contain stale buffer data never complete.
    assign completing = (row_q >= RowFirst) && (col_q >= ColFirst);

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_window = out_window_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Shift left; the new right column takes pre-update line buffer taps plus the live pixel.
    always_comb begin
        for (int r = 0; r < int'(KERNEL); r++) begin
            for (int c = 0; c < int'(KERNEL) - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < int'(KERNEL) - 1; r++) begin
            win_d[r][KERNEL-1] = lb_q[r][col_q];
        end
        win_d[KERNEL-1][KERNEL-1] = in_data;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < int'(KERNEL); r++) begin
            for (int c = 0; c < int'(KERNEL); c++) begin
                win_flat[D_WIDTH*(r*int'(KERNEL)+c) +: D_WIDTH] = win_d[r][c];
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_window_d = out_window_q;
        if (acc && completing) begin
            out_valid_d  = 1'b1;
            out_window_d = win_flat;
            out_last_d   = row_end && col_end;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_window_q <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_window_q <= out_window_d;
        end
    end

    // Pixel storage is never read before being written within a frame, so it needs no reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int j = 0; j < int'(KERNEL) - 2; j++) begin
                lb_q[j][col_q] <= lb_q[j+1][col_q];
            end
            lb_q[KERNEL-2][col_q] <= in_data;
            win_q <= win_d;
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer (K=3, 4x4 image): directed vector table,
// hand-written backpressure/reset sequences and a randomized run against an image model.
module tb_conv_window_buffer;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int WINW = DW * K * K;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [WINW-1:0] out_window;
    logic            out_last;

    conv_window_buffer #(
        .D_WIDTH   (DW),
        .KERNEL    (K),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_window(out_window),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [WINW-1:0] act, input logic [WINW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Window whose top-left pixel value is t, for a raster stream of consecutive values.
    function automatic logic [WINW-1:0] mkwin(input int t);
        logic [WINW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[DW*(r*K+c) +: DW] = DW'(t + r*W + c);
        return w;
    endfunction

    // Reference model: a whole-image array filled in raster order, windows cut from it.
    typedef struct {
        logic [WINW-1:0] w;
        logic            l;
    } win_t;

    logic [DW-1:0] img [H][W];
    int   m_row, m_col, m_accepted, m_consumed, m_lasts;
    logic m_valid;
    win_t m_q[$];

    task automatic model_reset();
        m_row = 0; m_col = 0; m_accepted = 0; m_consumed = 0; m_lasts = 0;
        m_valid = 1'b0;
        m_q.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] d, output logic completing);
        win_t e;
        img[m_row][m_col] = d;
        completing = (m_row >= K-1) && (m_col >= K-1);
        if (completing) begin
            e.w = '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    e.w[DW*(r*K+c) +: DW] = img[m_row-K+1+r][m_col-K+1+c];
            e.l = (m_row == H-1) && (m_col == W-1);
            m_q.push_back(e);
        end
        m_accepted++;
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row = (m_row + 1) % H;
        end
    endtask

    // Called at a negedge; drives one cycle and checks against the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy);
        logic completing;
        win_t e;
        in_valid = v; in_data = d; out_ready = ordy;
        #1;
        chk("out_valid", WINW'(out_valid), WINW'(m_valid));
        chk("in_ready", WINW'(in_ready), WINW'(!m_valid || ordy));
        if (m_valid && ordy) begin
            if (m_q.size() == 0) begin
                chk("spurious_window", 1, 0);
            end else begin
                e = m_q.pop_front();
                chk("window", out_window, e.w);
                chk("out_last", WINW'(out_last), WINW'(e.l));
                m_consumed++;
                if (e.l) m_lasts++;
            end
        end
        completing = 1'b0;
        if (v && (!m_valid || ordy)) model_accept(d, completing);
        if (completing) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [DW-1:0]   d;
        logic            v;
        logic [WINW-1:0] w;
        logic            l;
    } vec_t;

    vec_t tbl [32];

    initial begin
        // Two back-to-back frames: expected output after each pixel's accept.
        for (int i = 0; i < 32; i++) begin
            tbl[i].d = DW'(i); tbl[i].v = 1'b0; tbl[i].w = '0; tbl[i].l = 1'b0;
        end
        tbl[10] = '{d: 8'd10, v: 1'b1, w: mkwin(0),  l: 1'b0};
        tbl[11] = '{d: 8'd11, v: 1'b1, w: mkwin(1),  l: 1'b0};
        tbl[14] = '{d: 8'd14, v: 1'b1, w: mkwin(4),  l: 1'b0};
        tbl[15] = '{d: 8'd15, v: 1'b1, w: mkwin(5),  l: 1'b1};
        tbl[26] = '{d: 8'd26, v: 1'b1, w: mkwin(16), l: 1'b0};
        tbl[27] = '{d: 8'd27, v: 1'b1, w: mkwin(17), l: 1'b0};
        tbl[30] = '{d: 8'd30, v: 1'b1, w: mkwin(20), l: 1'b0};
        tbl[31] = '{d: 8'd31, v: 1'b1, w: mkwin(21), l: 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #3;
        chk("rst_out_valid", WINW'(out_valid), '0);
        chk("rst_out_last", WINW'(out_last), '0);
        chk("rst_out_window", out_window, '0);
        chk("rst_in_ready", WINW'(in_ready), WINW'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: continuous stream, out_ready held high.
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = tbl[i].d; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl_valid[%0d]", i), WINW'(out_valid), WINW'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("tbl_window[%0d]", i), out_window, tbl[i].w);
                chk($sformatf("tbl_last[%0d]", i), WINW'(out_last), WINW'(tbl[i].l));
            end
        end

        // Backpressure: stall after the first window for 5 cycles.
        do_reset();
        for (int i = 0; i <= 10; i++) step(1'b1, DW'(i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 8'd11; out_ready = 1'b0;
            #1;
            chk("bp_in_ready", WINW'(in_ready), '0);
            chk("bp_out_valid", WINW'(out_valid), WINW'(1));
            chk("bp_window_hold", out_window, mkwin(0));
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 11; i <= 15; i++) step(1'b1, DW'(i), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("bp_window_count", WINW'(m_consumed), WINW'(4));
        chk("bp_queue_empty", WINW'(m_q.size()), '0);

        // Reset in the middle of a frame.
        do_reset();
        for (int i = 0; i <= 9; i++) step(1'b1, DW'(i), 1'b1);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_valid_a", WINW'(out_valid), '0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid_b", WINW'(out_valid), '0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 100; i <= 110; i++) step(1'b1, DW'(i), 1'b1);
        chk("midrst_first_window", out_window, mkwin(100));
        for (int i = 111; i <= 115; i++) step(1'b1, DW'(i), 1'b1);
        step(1'b0, '0, 1'b1);
        chk("midrst_window_count", WINW'(m_consumed), WINW'(4));

        // Randomly throttled stream over 3 frames.
        do_reset();
        begin
            int cyc;
            cyc = 0;
            while (m_accepted < 3*W*H && cyc < 3000) begin
                step(($urandom_range(0, 9) < 7), DW'($urandom_range(0, 255)),
                     ($urandom_range(0, 9) < 6));
                cyc++;
            end
            if (m_accepted < 3*W*H) chk("rand_timeout", WINW'(m_accepted), WINW'(3*W*H));
            for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
        end
        chk("rand_window_count", WINW'(m_consumed), WINW'(12));
        chk("rand_last_count", WINW'(m_lasts), WINW'(3));
        chk("rand_queue_empty", WINW'(m_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
